alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 110 +++++++++++
 tb/tb_alu_result_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Result FIFO for ALU outputs: stores each 32-bit result with its four flags,
// and accumulates sticky carry/overflow across pushes until cleared.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_r,
    input  logic          in_zero,
    input  logic          in_carry,
    input  logic          in_negative,
    input  logic          in_overflow,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_r,
    output logic          out_zero,
    output logic          out_carry,
    output logic          out_negative,
    output logic          out_overflow,
    output logic [AW:0]   count,
    output logic          sticky_carry,
    output logic          sticky_overflow,
    input  logic          clr_sticky
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [35:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          sticky_carry_q, sticky_carry_d;
    logic          sticky_overflow_q, sticky_overflow_d;
    logic          push, pop;
    logic [35:0]   head;

    assign in_ready  = (count_q != FullCount);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        count_d           = count_q;
        sticky_carry_d    = sticky_carry_q;
        sticky_overflow_d = sticky_overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // Clear first so a qualifying push in the same cycle wins.
        if (clr_sticky) begin
            sticky_carry_d    = 1'b0;
            sticky_overflow_d = 1'b0;
        end
        if (push && in_carry) begin
            sticky_carry_d = 1'b1;
        end
        if (push && in_overflow) begin
            sticky_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            sticky_carry_q    <= 1'b0;
            sticky_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            sticky_carry_q    <= sticky_carry_d;
            sticky_overflow_q <= sticky_overflow_d;
        end
    end

    // Storage is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= {in_overflow, in_negative, in_carry, in_zero, in_r};
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign out_r           = head[31:0];
    assign out_zero        = head[32];
    assign out_carry       = head[33];
    assign out_negative    = head[34];
    assign out_overflow    = head[35];
    assign count           = count_q;
    assign sticky_carry    = sticky_carry_q;
    assign sticky_overflow = sticky_overflow_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed pushes queue expected words,
// a negedge monitor checks every popped head against the queue.
module tb_alu_result_fifo;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_r;
    logic        in_zero, in_carry, in_negative, in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic        out_zero, out_carry, out_negative, out_overflow;
    logic [2:0]  count;
    logic        sticky_carry, sticky_overflow;
    logic        clr_sticky;

    int total = 0;
    int bad   = 0;
    logic [35:0] exp_q[$];

    alu_result_fifo #(.DEPTH(4), .AW(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_r           (in_r),
        .in_zero        (in_zero),
        .in_carry       (in_carry),
        .in_negative    (in_negative),
        .in_overflow    (in_overflow),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_r          (out_r),
        .out_zero       (out_zero),
        .out_carry      (out_carry),
        .out_negative   (out_negative),
        .out_overflow   (out_overflow),
        .count          (count),
        .sticky_carry   (sticky_carry),
        .sticky_overflow(sticky_overflow),
        .clr_sticky     (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 after posedge, so at negedge they are stable for the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %h, expected no entry",
                         {out_overflow, out_negative, out_carry, out_zero, out_r});
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({out_overflow, out_negative, out_carry, out_zero, out_r} !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %h, expected %h",
                             {out_overflow, out_negative, out_carry, out_zero, out_r}, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Present one entry; the expected word is queued as the stimulus is issued.
    task automatic drive(input logic [31:0] r, input logic z, input logic c,
                         input logic n, input logic v);
        in_valid    = 1'b1;
        in_r        = r;
        in_zero     = z;
        in_carry    = c;
        in_negative = n;
        in_overflow = v;
        exp_q.push_back({v, n, c, z, r});
    endtask

    task automatic idle_in();
        in_valid    = 1'b0;
        in_carry    = 1'b0;
        in_overflow = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 20) begin
            cyc();
            n++;
        end
        out_ready = 1'b0;
        chk("drain_done", {31'b0, out_valid}, 32'd0);
        chk("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_r = '0; in_zero = 1'b0; in_carry = 1'b0;
        in_negative = 1'b0; in_overflow = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        #1;
        cyc();
        cyc();
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_stickies", {30'b0, sticky_carry, sticky_overflow}, 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single entry, latency 1
        drive(32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle_in();
        chk("single_out_valid", {31'b0, out_valid}, 32'd1);
        chk("single_out_r", out_r, 32'h5);
        chk("single_count", {29'b0, count}, 32'd1);
        drain();
        chk("single_count_after", {29'b0, count}, 32'd0);

        // Fill, overflow attempt, full pop-only, then drain in order
        drive(32'h11, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(32'h22, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        drive(32'h33, 1'b0, 1'b0, 1'b1, 1'b0); cyc();
        drive(32'h44, 1'b1, 1'b0, 1'b1, 1'b0); cyc();
        drive(32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("full_count", {29'b0, count}, 32'd4);
        cyc();
        chk("full_hold_count", {29'b0, count}, 32'd4);
        out_ready = 1'b1;
        cyc();
        chk("full_pop_only_count", {29'b0, count}, 32'd3);
        chk("full_pop_in_ready", {31'b0, in_ready}, 32'd1);
        cyc();
        idle_in();
        chk("push_pop_count3", {29'b0, count}, 32'd3);
        drain();

        // Simultaneous push and pop at count=2
        drive(32'hA1, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(32'hA2, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(32'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        cyc();
        idle_in();
        out_ready = 1'b0;
        chk("push_pop_count2", {29'b0, count}, 32'd2);
        drain();

        // Interleaved 1:1 traffic wraps the pointers several times
        for (int i = 1; i <= 10; i++) begin
            drive(i, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
            idle_in();
            chk("wrap_count_one", {29'b0, count}, 32'd1);
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
            chk("wrap_count_zero", {29'b0, count}, 32'd0);
        end
        chk("wrap_queue_empty", exp_q.size(), 32'd0);

        // Sticky flags
        clr_sticky = 1'b1;
        cyc();
        clr_sticky = 1'b0;
        chk("sticky_cleared", {30'b0, sticky_carry, sticky_overflow}, 32'd0);
        drive(32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        idle_in();
        chk("sticky_carry_set", {31'b0, sticky_carry}, 32'd1);
        chk("sticky_ovf_clear", {31'b0, sticky_overflow}, 32'd0);
        drive(32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
        clr_sticky = 1'b1;
        cyc();
        idle_in();
        clr_sticky = 1'b0;
        chk("sticky_set_wins_ovf", {31'b0, sticky_overflow}, 32'd1);
        chk("sticky_clr_carry", {31'b0, sticky_carry}, 32'd0);
        drain();
        chk("sticky_pop_holds", {30'b0, sticky_carry, sticky_overflow}, 32'd1);

        // Reset mid-run discards entries; a push in the reset cycle is ignored
        drive(32'h1, 1'b0, 1'b1, 1'b0, 1'b1); cyc();
        drive(32'h2, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(32'h3, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        chk("pre_rst_count", {29'b0, count}, 32'd3);
        in_valid = 1'b1;
        in_r = 32'hDEAD;
        out_ready = 1'b1;
        rst_n = 1'b0;
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
        idle_in();
        out_ready = 1'b0;
        chk("midrst_count", {29'b0, count}, 32'd0);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_stickies", {30'b0, sticky_carry, sticky_overflow}, 32'd0);
        cyc();
        drive(32'hABCD, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle_in();
        chk("post_midrst_out_r", out_r, 32'hABCD);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
